hidden_neuron_mac: RTL and testbench
====================================

HIDDEN_NEURON_MAC -- requirements
Module: hidden_neuron_mac

Interface
REQ-001 Parameter N_INPUTS, default 4, is the number of input/weight beats per evaluation; legal range 1..8.
REQ-002 Parameter X_W, default 10, is the activation width (unsigned, 3 integer bits and 7 fractional bits, Q3.7).
REQ-003 Parameter W_W, default 8, is the weight width (signed two's complement, Q1.7).
REQ-004 Parameter ACC_W, default 21, is the accumulator width (signed).
REQ-005 Port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port en_i, input, 1 bit: global enable; when low, all state and outputs hold.
REQ-008 Port start_i, input, 1 bit: a one-cycle pulse that begins an evaluation.
REQ-009 Port in_valid_i, input, 1 bit: x_i and w_i carry a valid beat.
REQ-010 Port in_ready_o, output, 1 bit: the block accepts a beat.
REQ-011 Port x_i, input, X_W bits: activation, unsigned.
REQ-012 Port w_i, input, W_W bits: weight, signed.
REQ-013 Port out_valid_o, output, 1 bit: out_data_o holds a result.
REQ-014 Port out_ready_i, input, 1 bit: the consumer (output neuron x input) accepts the result.
REQ-015 Port out_data_o, output, X_W bits: activation result, unsigned Q3.7.
REQ-016 Port busy_o, output, 1 bit: the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM and OUT.
REQ-018 In IDLE, start_i with en_i high SHALL load the accumulator with 0 (or with the bias, per REQ-031), clear the beat counter, and move to ACCUM.
REQ-019 In ACCUM, in_ready_o SHALL be 1; a beat is accepted when in_valid_i && in_ready_o && en_i are all high.
REQ-020 Each accepted beat SHALL add the signed product of zero-extended x_i and w_i, sign-extended to ACC_W, to the accumulator, and SHALL increment the counter.
REQ-021 When the beat with counter == N_INPUTS-1 is accepted, the block SHALL register out_data_o from the post-add accumulator value and enter OUT; out_valid_o rises on the next edge (latency 1 cycle).
REQ-022 The result SHALL be formed as follows:
- Negative sum → 0 (ReLU).
- Otherwise, arithmetic shift right by 7 (truncate).
- Values above 2^X_W-1 saturate to 2^X_W-1.
REQ-023 In OUT, out_valid_o SHALL be 1 and out_data_o SHALL be stable until out_valid_o && out_ready_i; on that cycle the block returns to IDLE.
REQ-024 start_i SHALL be ignored in the ACCUM and OUT states.
REQ-025 start_i arriving in the same cycle as the output handshake SHALL be ignored; only IDLE samples start_i.
REQ-026 in_ready_o SHALL be 0 in the IDLE and OUT states, so beats are not accepted there.
REQ-027 The accumulator SHALL never overflow for N_INPUTS ≤ 8: the maximum magnitude is 8·1023·128 = 1,047,552, which is below 2^20.

Reset
REQ-028 While rst_i is low, the block SHALL be asynchronously forced to:
- state IDLE, counter 0, accumulator 0;
- out_data_o = 0, out_valid_o = 0, in_ready_o = 0, busy_o = 0.
REQ-029 Reset asserted during ACCUM or OUT SHALL abandon the evaluation; after release, no out_valid_o pulse occurs until a new start_i.

Configuration
REQ-030 The macro HIDDEN_NEURON_BIAS_EN SHALL compile in the bias feature.
REQ-031 With HIDDEN_NEURON_BIAS_EN defined, an input port bias_i of 16 bits (signed, Q8.7) SHALL be present; on start_i the accumulator loads sign-extended bias_i.
REQ-032 Without HIDDEN_NEURON_BIAS_EN, the bias_i port SHALL be absent and the accumulator SHALL load 0 on start_i.

Structure
REQ-033 The shared package nn_pkg SHALL hold:
- FRAC_BITS = 7;
- the default X_W, W_W and ACC_W values;
- the FSM state typedef (IDLE, ACCUM, OUT).
REQ-034 A single sub-module relu_sat SHALL perform the combinational ReLU, shift and saturation, ACC_W → X_W; it is reused by the output stage.

Verification
REQ-035 Basic evaluation: N=4, x = {100, 200, 300, 400}, w = 64 on every beat → out_data_o = 500, with out_valid_o one cycle after the 4th beat.
REQ-036 Saturation: x = 1023 and w = 127 on all 4 beats → out_data_o = 1023.
REQ-037 ReLU: x = {100, 200, 300, 400}, w = -64 on every beat → out_data_o = 0.
REQ-038 Backpressure and gaps:
- out_ready_i held low for 3 cycles → out_valid_o and out_data_o stay constant, and start_i pulses in that window are ignored;
- in_valid_i gaps during ACCUM are tolerated.
REQ-039 Reset mid-operation: rst_i pulsed low after beat 2 → out_valid_o = 0, busy_o = 0; a fresh evaluation afterwards yields the correct result.
REQ-040 Bias: with HIDDEN_NEURON_BIAS_EN defined, bias_i = 1280 and all beats w = 0 → out_data_o = 10.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: fixed-point
// format constants, default widths and the MAC controller state encoding.
package nn_pkg;

    localparam int FRAC_BITS = 7;
    localparam int X_W_DEF   = 10;
    localparam int W_W_DEF   = 8;
    localparam int ACC_W_DEF = 21;
    localparam int BIAS_W    = 16;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/relu_sat.sv
// Converts a signed Q.7 accumulator into an unsigned Q3.7 activation:
// negative values clamp to zero, the rest truncate and saturate.
module relu_sat
    import nn_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int X_W   = X_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [X_W-1:0]   act
);

    function automatic logic [X_W-1:0] relu_sat_f(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC_BITS;
        if (a[ACC_W-1])
            return '0;
        else if (|sh[ACC_W-1:X_W])
            return '1;
        else
            return sh[X_W-1:0];
    endfunction

    assign act = relu_sat_f(acc);

endmodule

// File: rtl/hidden_neuron_mac.sv
// Hidden-layer neuron: accumulates N_INPUTS activation x weight beats and
// emits a ReLU-saturated activation. Define HIDDEN_NEURON_BIAS_EN for a bias input.
module hidden_neuron_mac
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int X_W      = X_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [X_W-1:0]       x_i,
    input  logic [W_W-1:0]       w_i,
`ifdef HIDDEN_NEURON_BIAS_EN
    input  logic [BIAS_W-1:0]    bias_i,
`endif
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [X_W-1:0]       out_data_o,
    output logic                 busy_o
);

    localparam int PROD_W = X_W + W_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt_p0;
    logic signed [ACC_W-1:0]   acc_p0;
    logic [X_W-1:0]            data_p1;

    logic signed [X_W:0]       x_s;
    logic signed [W_W-1:0]     w_s;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   acc_init;
    logic [X_W-1:0]            act;
    logic                      beat;
    logic                      last_beat;

    // Activation is unsigned, so a zero MSB makes the signed multiply exact.
    assign x_s  = {1'b0, x_i};
    assign w_s  = w_i;
    assign prod = PROD_W'(x_s) * PROD_W'(w_s);
    assign sum  = acc_p0 + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

`ifdef HIDDEN_NEURON_BIAS_EN
    assign acc_init = $signed({{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i});
`else
    assign acc_init = '0;
`endif

    assign beat      = in_valid_i && in_ready_o && en_i;
    assign last_beat = beat && (cnt_p0 == LAST_CNT);

    relu_sat #(.ACC_W(ACC_W), .X_W(X_W)) u_relu_sat (
        .acc (sum),
        .act (act)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= IDLE;
        else if (en_i)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i)     state_nxt = ACCUM;
            ACCUM:   if (last_beat)   state_nxt = OUT;
            OUT:     if (out_ready_i) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == ACCUM);
        out_valid_o = (state == OUT);
        busy_o      = (state != IDLE);
    end

    // Stage p0: accumulate beats; stage p1: registered activation result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_p0  <= '0;
            cnt_p0  <= '0;
            data_p1 <= '0;
        end else if (en_i) begin
            if (state == IDLE && start_i) begin
                acc_p0 <= acc_init;
                cnt_p0 <= '0;
            end else if (beat) begin
                acc_p0 <= sum;
                cnt_p0 <= cnt_p0 + CNT_W'(1);
                if (last_beat)
                    data_p1 <= act;
            end
        end
    end

    assign out_data_o = data_p1;

endmodule

// File: tb/tb_hidden_neuron_mac.sv
// Directed bench for hidden_neuron_mac with hand-computed expected results.
module tb_hidden_neuron_mac;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b1;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [9:0]  x_i = '0;
    logic [7:0]  w_i = '0;
`ifdef HIDDEN_NEURON_BIAS_EN
    logic [15:0] bias_i = '0;
`endif
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [9:0]  out_data_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    hidden_neuron_mac dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .w_i         (w_i),
`ifdef HIDDEN_NEURON_BIAS_EN
        .bias_i      (bias_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic beat(input logic [9:0] x, input logic [7:0] w);
        in_valid_i = 1'b1;
        x_i = x;
        w_i = w;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_in_ready", 32'(in_ready_o), 0);
        check("rst_out_data", 32'(out_data_o), 0);
        rst_i = 1'b1;
        step();

        // Beat in IDLE must be ignored
        beat(10'd1023, 8'd127);
        check("idle_busy", 32'(busy_o), 0);

        // Basic: (100+200+300+400)*64 = 64000 >> 7 = 500
        pulse_start();
        check("basic_busy", 32'(busy_o), 1);
        check("basic_in_ready", 32'(in_ready_o), 1);
        beat(10'd100, 8'd64);
        beat(10'd200, 8'd64);
        beat(10'd300, 8'd64);
        check("basic_no_early_valid", 32'(out_valid_o), 0);
        beat(10'd400, 8'd64);
        check("basic_valid", 32'(out_valid_o), 1);
        check("basic_data", 32'(out_data_o), 500);
        check("basic_out_in_ready", 32'(in_ready_o), 0);
        drain();
        check("basic_done_valid", 32'(out_valid_o), 0);
        check("basic_done_busy", 32'(busy_o), 0);

        // Saturation: 4*1023*127 = 519684 >> 7 = 4060 -> 1023
        pulse_start();
        for (int i = 0; i < 4; i++) beat(10'd1023, 8'd127);
        check("sat_valid", 32'(out_valid_o), 1);
        check("sat_data", 32'(out_data_o), 1023);
        drain();

        // ReLU: -64000 -> 0
        pulse_start();
        beat(10'd100, -8'sd64);
        beat(10'd200, -8'sd64);
        beat(10'd300, -8'sd64);
        beat(10'd400, -8'sd64);
        check("relu_valid", 32'(out_valid_o), 1);
        check("relu_data", 32'(out_data_o), 0);
        drain();

        // Mixed signs with en_i low stalls: 129921-65536+50+0 = 64435 >> 7 = 503
        pulse_start();
        beat(10'd1023, 8'd127);
        en_i = 1'b0;
        in_valid_i = 1'b1;
        x_i = 10'd1023;
        w_i = 8'd127;
        step();
        step();
        in_valid_i = 1'b0;
        en_i = 1'b1;
        check("en_hold_busy", 32'(busy_o), 1);
        check("en_hold_valid", 32'(out_valid_o), 0);
        beat(10'd512, -8'sd128);
        beat(10'd1, 8'd50);
        beat(10'd0, -8'sd1);
        check("mixed_valid", 32'(out_valid_o), 1);
        check("mixed_data", 32'(out_data_o), 503);
        en_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        check("en_low_out_hold", 32'(out_valid_o), 1);
        en_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        check("mixed_done_valid", 32'(out_valid_o), 0);

        // Gaps and backpressure: (10+20+30+40)*127 = 12700 >> 7 = 99
        pulse_start();
        beat(10'd10, 8'd127);
        step();
        step();
        beat(10'd20, 8'd127);
        step();
        beat(10'd30, 8'd127);
        beat(10'd40, 8'd127);
        for (int i = 0; i < 3; i++) begin
            start_i = (i == 1);
            step();
            check("bp_valid", 32'(out_valid_o), 1);
            check("bp_data", 32'(out_data_o), 99);
        end
        out_ready_i = 1'b1;
        start_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        start_i = 1'b0;
        check("hs_start_ignored_busy", 32'(busy_o), 0);
        step();
        check("hs_still_idle", 32'(busy_o), 0);

        // Reset after beat 2 abandons the evaluation
        pulse_start();
        beat(10'd100, 8'd64);
        beat(10'd200, 8'd64);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_data", 32'(out_data_o), 0);
        step();
        #3;
        rst_i = 1'b1;
        in_valid_i = 1'b1;
        x_i = 10'd300;
        w_i = 8'd64;
        step();
        step();
        in_valid_i = 1'b0;
        check("post_rst_valid", 32'(out_valid_o), 0);
        check("post_rst_busy", 32'(busy_o), 0);
        pulse_start();
        beat(10'd100, 8'd64);
        beat(10'd200, 8'd64);
        beat(10'd300, 8'd64);
        beat(10'd400, 8'd64);
        check("post_rst_data", 32'(out_data_o), 500);
        check("post_rst_out_valid", 32'(out_valid_o), 1);
        drain();

`ifdef HIDDEN_NEURON_BIAS_EN
        // Bias 1280 (10.0 in Q8.7) with zero weights -> 10
        bias_i = 16'd1280;
        pulse_start();
        for (int i = 0; i < 4; i++) beat(10'd500, 8'd0);
        check("bias_data", 32'(out_data_o), 10);
        drain();
        bias_i = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
